// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter and its helpers.
package vga_fb_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned COORD_W  = 11;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned FB_SHIFT = 2;
    localparam int unsigned FB_W     = H_ACTIVE >> FB_SHIFT;
    localparam int unsigned FB_H     = V_ACTIVE >> FB_SHIFT;
    localparam int unsigned FB_WORDS = FB_W * FB_H;

    // Owner of the RAM read issued in the previous cycle.
    typedef enum logic [1:0] {
        TagNone,
        TagDisp,
        TagHost
    } rd_tag_e;

    // ACK spends one cycle ignoring a still-held request.
    typedef enum logic {
        StIdle,
        StAck
    } host_st_e;

endpackage

// File: rtl/vga_fb_addr_calc.sv
// Downscales a screen coordinate and maps it to a linear frame-buffer word address.
// The row multiply is a constant shift-add, so no hard multiplier is inferred.
module vga_fb_addr_calc #(
    parameter int unsigned COORD_W  = vga_fb_pkg::COORD_W,
    parameter int unsigned ADDR_W   = vga_fb_pkg::ADDR_W,
    parameter int unsigned FB_SHIFT = vga_fb_pkg::FB_SHIFT,
    parameter int unsigned FB_W     = vga_fb_pkg::FB_W
) (
    input  logic [COORD_W-1:0] row_i,
    input  logic [COORD_W-1:0] col_i,
    output logic [ADDR_W-1:0]  addr_o
);

    localparam logic [31:0] FbWBits = 32'(FB_W);

    logic [ADDR_W-1:0] row_ds;
    logic [ADDR_W-1:0] col_ds;
    logic [ADDR_W-1:0] acc;

    // addr = row_ds * FB_W + col_ds, summed over the set bits of FB_W, truncated to ADDR_W.
    always_comb begin
        row_ds = ADDR_W'(row_i >> FB_SHIFT);
        col_ds = ADDR_W'(col_i >> FB_SHIFT);
        acc    = col_ds;
        for (int b = 0; b < 32; b++) begin
            if (FbWBits[b]) begin
                acc = acc + (row_ds << b);
            end
        end
        addr_o = acc;
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Time-division arbiter for a single-port frame-buffer RAM shared by VGA scanout and a host port.
// A 4-cycle phase counter runs in lock-step with the pixel divider: ph1 is the display slot,
// every other cycle (and an unused ph1) serves the host.
module vga_fb_arbiter #(
    parameter int unsigned          DATA_W   = vga_fb_pkg::DATA_W,
    parameter int unsigned          ADDR_W   = vga_fb_pkg::ADDR_W,
    parameter int unsigned          H_ACTIVE = vga_fb_pkg::H_ACTIVE,
    parameter int unsigned          V_ACTIVE = vga_fb_pkg::V_ACTIVE,
    parameter int unsigned          FB_SHIFT = vga_fb_pkg::FB_SHIFT,
    parameter logic [DATA_W-1:0]    BG_COLOR = '0
) (
    input  logic                            CLK,
    input  logic                            RSTn,
    input  logic                            Disp_En,
    input  logic                            Disp_Active,
    input  logic [vga_fb_pkg::COORD_W-1:0]  Col_Addr,
    input  logic [vga_fb_pkg::COORD_W-1:0]  Row_Addr,
    output logic [DATA_W-1:0]               Pixel_Data,
    input  logic                            Host_Req,
    input  logic                            Host_We,
    input  logic [ADDR_W-1:0]               Host_Addr,
    input  logic [DATA_W-1:0]               Host_WData,
    output logic                            Host_Ack,
    output logic                            Host_Err,
    output logic [DATA_W-1:0]               Host_RData,
    output logic                            Host_RValid,
    output logic [ADDR_W-1:0]               Mem_Addr,
    output logic                            Mem_We,
    output logic [DATA_W-1:0]               Mem_WData,
    input  logic [DATA_W-1:0]               Mem_RData
);

    localparam int unsigned FB_W     = H_ACTIVE >> FB_SHIFT;
    localparam int unsigned FB_H     = V_ACTIVE >> FB_SHIFT;
    localparam int unsigned FB_WORDS = FB_W * FB_H;

    import vga_fb_pkg::*;

    logic [1:0]        ph_q, ph_d;
    host_st_e          st_q, st_d;
    rd_tag_e           tag_q, tag_d;
    logic              rd_zero_q, rd_zero_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] pixel_q, pixel_d;

    logic [ADDR_W-1:0] disp_addr;
    logic              disp_slot;
    logic              addr_bad;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              host_ack;
    logic              host_err;

    vga_fb_addr_calc #(
        .COORD_W  (COORD_W),
        .ADDR_W   (ADDR_W),
        .FB_SHIFT (FB_SHIFT),
        .FB_W     (FB_W)
    ) u_addr_calc (
        .row_i  (Row_Addr),
        .col_i  (Col_Addr),
        .addr_o (disp_addr)
    );

    assign disp_slot = (ph_q == 2'd1) && Disp_En && Disp_Active;
    assign addr_bad  = 32'(Host_Addr) >= FB_WORDS;

    // Phase counter, free-running modulo 4.
    always_comb begin
        ph_d = ph_q + 2'd1;
    end

    // Slot arbitration and host FSM: display owns ph1, the host takes any other cycle.
    always_comb begin
        st_d      = st_q;
        tag_d     = TagNone;
        rd_zero_d = 1'b0;
        mem_addr  = mem_addr_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        host_ack  = 1'b0;
        host_err  = 1'b0;

        if (disp_slot) begin
            mem_addr = disp_addr;
            tag_d    = TagDisp;
        end

        unique case (st_q)
            StIdle: begin
                if (Host_Req && !disp_slot) begin
                    host_ack = 1'b1;
                    st_d     = StAck;
                    if (addr_bad) begin
                        // No RAM access; a read still completes, returning zero.
                        host_err = 1'b1;
                        if (!Host_We) begin
                            tag_d     = TagHost;
                            rd_zero_d = 1'b1;
                        end
                    end else begin
                        mem_addr = Host_Addr;
                        if (Host_We) begin
                            mem_we    = 1'b1;
                            mem_wdata = Host_WData;
                        end else begin
                            tag_d = TagHost;
                        end
                    end
                end
            end
            StAck: begin
                st_d = StIdle;
            end
        endcase

        mem_addr_d = mem_addr;
    end

    // Pixel register reloads at the end of ph2, when a display read from ph1 has returned.
    always_comb begin
        pixel_d = pixel_q;
        if (ph_q == 2'd2) begin
            if (tag_q == TagDisp) begin
                pixel_d = Mem_RData;
            end else if (Disp_En) begin
                pixel_d = '0;
            end else begin
                pixel_d = BG_COLOR;
            end
        end
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ph_q       <= 2'd0;
            st_q       <= StIdle;
            tag_q      <= TagNone;
            rd_zero_q  <= 1'b0;
            mem_addr_q <= '0;
            pixel_q    <= '0;
        end else begin
            ph_q       <= ph_d;
            st_q       <= st_d;
            tag_q      <= tag_d;
            rd_zero_q  <= rd_zero_d;
            mem_addr_q <= mem_addr_d;
            pixel_q    <= pixel_d;
        end
    end

    assign Pixel_Data  = pixel_q;
    assign Host_Ack    = host_ack;
    assign Host_Err    = host_err;
    assign Host_RValid = (tag_q == TagHost);
    assign Host_RData  = (tag_q == TagHost && !rd_zero_q) ? Mem_RData : '0;
    assign Mem_Addr    = mem_addr;
    assign Mem_We      = mem_we;
    assign Mem_WData   = mem_wdata;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Time-division scheduler for one single-port frame-buffer RAM, shared between VGA scanout and a host read/write port. It runs in lock-step with the 640x480 sync generator's divide-by-4 pixel divider. Every pixel period has one display slot, and every other cycle is a host slot. The block outputs the registered pixel colour for the DAC/RGB pins.

Parameters:
DATA_W, 8, pixel/RAM word width (RGB332)
ADDR_W, 15, RAM address width
H_ACTIVE, 640, visible columns from timing generator
V_ACTIVE, 480, visible rows
FB_SHIFT, 2, downscale; frame buffer is (H_ACTIVE>>FB_SHIFT) x (V_ACTIVE>>FB_SHIFT) = 160x120
BG_COLOR, 8'h00, colour driven when display disabled

Ports:
CLK  in  1  system clock (100 MHz; pixel = 4 CLK)
RSTn  in  1  asynchronous active-low reset
Disp_En  in  1  1 = scanout enabled
Disp_Active  in  1  timing generator ready/active-video flag
Col_Addr  in  11  active column, 0-based
Row_Addr  in  11  active row, 0-based
Pixel_Data  out  DATA_W  registered colour to RGB pins
Host_Req  in  1  host request, held until Host_Ack
Host_We  in  1  1 = write, 0 = read
Host_Addr  in  ADDR_W  host word address
Host_WData  in  DATA_W  write data
Host_Ack  out  1  one-CLK pulse: request accepted
Host_Err  out  1  one-CLK pulse with Host_Ack: address out of range
Host_RData  out  DATA_W  read data
Host_RValid  out  1  one-CLK pulse: Host_RData valid
Mem_Addr  out  ADDR_W  RAM address
Mem_We  out  1  RAM write strobe
Mem_WData  out  DATA_W  RAM write data
Mem_RData  in  DATA_W  RAM read data, valid 1 CLK after address

Behaviour:
- Reset: all outputs 0, Pixel_Data = 0, phase = 0, pending read tag cleared. Mid-operation reset drops any in-flight read; no Host_RValid follows.
- Phase counter ph (2 bits) counts 0,1,2,3,0… every CLK. It leaves reset together with the timing generator's divider, so ph==0 coincides with its divider value 0.
- Display slot = ph==1. If Disp_En && Disp_Active:
  - Mem_Addr = (Row_Addr>>FB_SHIFT)*FB_W + (Col_Addr>>FB_SHIFT), with FB_W = H_ACTIVE>>FB_SHIFT.
  - Multiply is implemented as shift-add (160 = 128+32). Result truncated to ADDR_W.
  - Mem_We = 0; tag = DISP.
- Pixel_Data update at the end of ph==2:
  - tag DISP -> Mem_RData.
  - display slot unused and Disp_En=1 -> 0 (black in blanking).
  - Disp_En=0 -> BG_COLOR.
  - Held for the remaining 4-cycle period. Fixed latency: Col/Row sampled at ph1, Pixel_Data changes 2 CLK later.
- Host slots: ph∈{0,2,3}, plus ph==1 when no display read is issued. During blanking or Disp_En=0 every cycle is a host slot.
- Host FSM, states IDLE / ACK:
  - IDLE: Host_Req in a host slot -> issue access combinationally on Mem_* and pulse Host_Ack.
  - Write: Mem_We=1, Mem_WData=Host_WData.
  - Read: tag=HOST; next CLK Host_RData=Mem_RData and Host_RValid=1.
  - ACK (1 CLK): ignore Host_Req so a held request is not double-served; return to IDLE.
  - Max wait from Host_Req to Host_Ack: 2 CLK (display slot + ACK gap).
- Host_Addr >= FB_W*(V_ACTIVE>>FB_SHIFT) (19200): Host_Ack and Host_Err pulse, no RAM access. A read also returns Host_RValid with Host_RData=0 next CLK.
- Simultaneous display slot and host request: display wins; host is served at ph==2.
- Read tags never collide: at most one read issued per CLK, latency exactly 1.
- Idle cycles: Mem_We=0, Mem_Addr holds last value.

Decomposition:
- Package vga_fb_pkg: DATA_W, ADDR_W, H_ACTIVE, V_ACTIVE, FB_SHIFT, derived FB_W/FB_H/FB_WORDS; read-tag enum {NONE, DISP, HOST}; host FSM state enum.
- Sub-module vga_fb_addr_calc: combinational row/col downscale + shift-add address, reused by future sprite/overlay blocks.

Test Plan:
- Reset held 5 CLK mid-frame with a host read in flight -> all outputs 0, no Host_RValid after release, ph restarts at 0.
- Disp_Active=1, Row=8, Col=12, FB_SHIFT=2 -> Mem_Addr=2*160+3=323 at ph1; RAM[323]=8'hA5 -> Pixel_Data=8'hA5 from the following ph3.
- Host write addr 100, data 8'h3C issued so it arrives at ph1 during active video -> Ack deferred to ph2, Mem_We=1 at ph2, wait = 1 CLK; read-back of addr 100 -> Host_RValid with 8'h3C.
- Host_Req held continuously during blanking -> Ack every 2 CLK (IDLE/ACK alternation), no double write per request.
- Host read addr 19200 -> Host_Ack+Host_Err same CLK, Mem_We=0, Host_RValid next CLK with 8'h00.
- Disp_En=0, BG_COLOR=8'h1F, Disp_Active=1 -> Pixel_Data=8'h1F, no display reads on Mem_Addr, host served in ph1 too.
